// File: rtl/mlp_pkg.sv
// Shared register map, CTRL bit positions, FSM encoding and the fixed-point
// shift/saturate helper used by the mlp_seq engine.
package mlp_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_INPUT  = 2'd1;
  localparam logic [1:0] ADDR_WEIGHT = 2'd2;
  localparam logic [1:0] ADDR_OUTPUT = 2'd3;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_DONE    = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_LAYER   = 3;
  localparam int CTRL_ACT     = 4;
  localparam int CTRL_PTR_CLR = 5;
  localparam int CTRL_BUSY    = 6;

  typedef enum logic [2:0] {
    ST_IDLE, ST_H_BIAS, ST_H_MAC, ST_H_WB, ST_O_BIAS, ST_O_MAC, ST_O_WB, ST_FIN
  } state_e;

  // Working width of the writeback path; wide enough for any sane MAC_WIDTH.
  localparam int SAT_W = 128;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Arithmetic right shift, then clamp into a signed ow-bit range.
  function automatic logic signed [SAT_W-1:0] shift_sat(input logic signed [SAT_W-1:0] v,
                                                        input int sh, input int ow);
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s  = v >>> sh;
    hi = (SAT_W'(1) << (ow - 1)) - SAT_W'(1);
    lo = ~hi;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/mlp_mac_unit.sv
// Shared accumulator: bias load, one signed multiply-accumulate per cycle, and a
// combinational shift/ReLU/saturate result; no backpressure, the FSM sequences it.
module mlp_mac_unit
  import mlp_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int WGT_WIDTH = 16,
  parameter int MAC_WIDTH = 64,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic                        step_i,
  input  logic signed [WGT_WIDTH-1:0] w_i,
  input  logic signed [A_WIDTH-1:0]   a_i,
  input  logic                        relu_i,
  output logic signed [OUT_WIDTH-1:0] res_o
);

  logic signed [MAC_WIDTH-1:0]         acc_q;
  logic signed [MAC_WIDTH-1:0]         acc_d;
  logic signed [WGT_WIDTH+A_WIDTH-1:0] prod;
  logic signed [SAT_W-1:0]             scaled;

  assign prod = w_i * a_i;

  // The bias arrives on the weight operand during the *_BIAS state.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = MAC_WIDTH'(w_i);
    end else if (step_i) begin
      acc_d = acc_q + MAC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // ReLU after the clamp is equivalent to before it, since 0 is always in range.
  always_comb begin
    scaled = shift_sat(SAT_W'(acc_q), FRAC_BITS, OUT_WIDTH);
    if (relu_i && scaled < 0) begin
      scaled = '0;
    end
  end

  assign res_o = scaled[OUT_WIDTH-1:0];

endmodule

// File: rtl/mlp_seq.sv
// Two-layer MLP engine on a 2-bit register bus; readdata lags addr by one cycle and a RUN stays busy
// N_HIDDEN*(N_INPUTS+2)+N_OUTPUT*(N_HIDDEN+2)+1 cycles. No backpressure: INPUT/WEIGHT/RUN writes
// are dropped while busy. Define MLP_PERF_CNT_EN for a busy-cycle counter in CTRL[31:16].
module mlp_seq
  import mlp_pkg::*;
#(
  parameter int N_INPUTS  = 2,
  parameter int N_HIDDEN  = 4,
  parameter int N_OUTPUT  = 1,
  parameter int IN_WIDTH  = 16,
  parameter int WGT_WIDTH = 16,
  parameter int MAC_WIDTH = 64,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic [1:0]  addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int A_WIDTH = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int WH_N    = N_HIDDEN * (N_INPUTS + 1);
  localparam int WO_N    = N_OUTPUT * (N_HIDDEN + 1);
  localparam int XAW     = idx_w(N_INPUTS);
  localparam int HAW     = idx_w(N_HIDDEN);
  localparam int OAW     = idx_w(N_OUTPUT);
  localparam int WHAW    = idx_w(WH_N);
  localparam int WOAW    = idx_w(WO_N);
  localparam int WPW     = (WHAW > WOAW) ? WHAW : WOAW;
  localparam int NW      = idx_w((N_HIDDEN > N_OUTPUT) ? N_HIDDEN : N_OUTPUT);
  localparam int KW      = idx_w((N_INPUTS > N_HIDDEN) ? N_INPUTS : N_HIDDEN);

  state_e           state_q, state_d;
  logic [NW-1:0]    n_q, n_d;
  logic [KW-1:0]    k_q, k_d;
  logic             done_q, irq_en_q, layer_q, act_q;
  logic [XAW-1:0]   in_ptr_q;
  logic [WPW-1:0]   w_ptr_q, w_last;
  logic [OAW-1:0]   rd_idx_q;
  logic [31:0]      readdata_q, rdata_d;
  logic [15:0]      perf_hi;

  logic signed [IN_WIDTH-1:0]  x_q  [N_INPUTS];
  logic signed [WGT_WIDTH-1:0] wh_q [WH_N];
  logic signed [WGT_WIDTH-1:0] wo_q [WO_N];
  logic signed [OUT_WIDTH-1:0] h_q  [N_HIDDEN];
  logic signed [OUT_WIDTH-1:0] y_q  [N_OUTPUT];

  logic busy, wr_ctrl, wr_input, wr_weight, wr_output, start;
  logic mac_load, mac_step, mac_relu, h_wr, y_wr, fin;
  logic [WHAW-1:0] wh_idx;
  logic [WOAW-1:0] wo_idx;
  logic signed [WGT_WIDTH-1:0] mac_w;
  logic signed [A_WIDTH-1:0]   mac_a;
  logic signed [OUT_WIDTH-1:0] mac_res;

  assign busy      = (state_q != ST_IDLE);
  assign wr_ctrl   = write_en && (addr == ADDR_CTRL);
  assign wr_input  = write_en && (addr == ADDR_INPUT) && !busy;
  assign wr_weight = write_en && (addr == ADDR_WEIGHT) && !busy;
  assign wr_output = write_en && (addr == ADDR_OUTPUT);
  assign start     = wr_ctrl && writedata[CTRL_RUN] && !busy;
  assign w_last    = layer_q ? WPW'(WO_N - 1) : WPW'(WH_N - 1);
  assign irq       = done_q & irq_en_q;
  assign readdata  = readdata_q;
  assign mac_relu  = (state_q == ST_H_WB) && !act_q;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    mac_load = 1'b0;
    mac_step = 1'b0;
    h_wr     = 1'b0;
    y_wr     = 1'b0;
    fin      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_H_BIAS;
          n_d     = '0;
          k_d     = '0;
        end
      end
      ST_H_BIAS: begin
        mac_load = 1'b1;
        k_d      = '0;
        state_d  = ST_H_MAC;
      end
      ST_H_MAC: begin
        mac_step = 1'b1;
        if (k_q == KW'(N_INPUTS - 1)) state_d = ST_H_WB;
        else                          k_d = k_q + KW'(1);
      end
      ST_H_WB: begin
        h_wr = 1'b1;
        if (n_q == NW'(N_HIDDEN - 1)) begin
          n_d     = '0;
          state_d = ST_O_BIAS;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = ST_H_BIAS;
        end
      end
      ST_O_BIAS: begin
        mac_load = 1'b1;
        k_d      = '0;
        state_d  = ST_O_MAC;
      end
      ST_O_MAC: begin
        mac_step = 1'b1;
        if (k_q == KW'(N_HIDDEN - 1)) state_d = ST_O_WB;
        else                          k_d = k_q + KW'(1);
      end
      ST_O_WB: begin
        y_wr = 1'b1;
        if (n_q == NW'(N_OUTPUT - 1)) begin
          state_d = ST_FIN;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = ST_O_BIAS;
        end
      end
      ST_FIN: begin
        fin     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Weight arrays are neuron-major with the bias at offset 0 of each row.
  always_comb begin
    wh_idx = WHAW'(int'(n_q) * (N_INPUTS + 1) + ((state_q == ST_H_MAC) ? int'(k_q) + 1 : 0));
    wo_idx = WOAW'(int'(n_q) * (N_HIDDEN + 1) + ((state_q == ST_O_MAC) ? int'(k_q) + 1 : 0));
    if (state_q inside {ST_O_BIAS, ST_O_MAC}) begin
      mac_w = wo_q[wo_idx];
      mac_a = A_WIDTH'(h_q[HAW'(k_q)]);
    end else begin
      mac_w = wh_q[wh_idx];
      mac_a = A_WIDTH'(x_q[XAW'(k_q)]);
    end
  end

  mlp_mac_unit #(
    .A_WIDTH   (A_WIDTH),
    .WGT_WIDTH (WGT_WIDTH),
    .MAC_WIDTH (MAC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .load_i (mac_load),
    .step_i (mac_step),
    .w_i    (mac_w),
    .a_i    (mac_a),
    .relu_i (mac_relu),
    .res_o  (mac_res)
  );

`ifdef MLP_PERF_CNT_EN
  logic [15:0] cyc_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (start) begin
      cyc_q <= '0;
    end else if (busy && cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end
  assign perf_hi = cyc_q;
`else
  assign perf_hi = '0;
`endif

  always_comb begin
    rdata_d = '0;
    unique case (addr)
      ADDR_CTRL: begin
        rdata_d[31:16]       = perf_hi;
        rdata_d[CTRL_DONE]   = done_q;
        rdata_d[CTRL_IRQ_EN] = irq_en_q;
        rdata_d[CTRL_LAYER]  = layer_q;
        rdata_d[CTRL_ACT]    = act_q;
        rdata_d[CTRL_BUSY]   = busy;
      end
      ADDR_OUTPUT: rdata_d = 32'(y_q[rd_idx_q]);
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      layer_q    <= 1'b0;
      act_q      <= 1'b0;
      in_ptr_q   <= '0;
      w_ptr_q    <= '0;
      rd_idx_q   <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      readdata_q <= rdata_d;
      if (wr_ctrl) begin
        irq_en_q <= writedata[CTRL_IRQ_EN];
        act_q    <= writedata[CTRL_ACT];
        if (writedata[CTRL_DONE]) done_q <= 1'b0;
        if (!busy) begin
          layer_q <= writedata[CTRL_LAYER];
          w_ptr_q <= '0;
          if (writedata[CTRL_PTR_CLR]) in_ptr_q <= '0;
        end
      end
      if (start) done_q <= 1'b0;
      if (fin)   done_q <= 1'b1;
      if (wr_input) begin
        in_ptr_q <= (in_ptr_q == XAW'(N_INPUTS - 1)) ? '0 : in_ptr_q + XAW'(1);
      end
      if (wr_weight) begin
        w_ptr_q <= (w_ptr_q == w_last) ? '0 : w_ptr_q + WPW'(1);
      end
      if (wr_output) begin
        rd_idx_q <= OAW'(writedata % 32'(N_OUTPUT));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_INPUTS; i++) x_q[i]  <= '0;
      for (int i = 0; i < WH_N; i++)     wh_q[i] <= '0;
      for (int i = 0; i < WO_N; i++)     wo_q[i] <= '0;
      for (int i = 0; i < N_HIDDEN; i++) h_q[i]  <= '0;
      for (int i = 0; i < N_OUTPUT; i++) y_q[i]  <= '0;
    end else begin
      if (wr_input) x_q[in_ptr_q] <= writedata[IN_WIDTH-1:0];
      if (wr_weight) begin
        if (layer_q) wo_q[WOAW'(w_ptr_q)] <= writedata[WGT_WIDTH-1:0];
        else         wh_q[WHAW'(w_ptr_q)] <= writedata[WGT_WIDTH-1:0];
      end
      if (h_wr) h_q[HAW'(n_q)] <= mac_res;
      if (y_wr) y_q[OAW'(n_q)] <= mac_res;
    end
  end

endmodule

// File: tb/tb_mlp_seq.sv
// Directed bench for mlp_seq: default build, a two-output 8-bit build and a FRAC_BITS=2 build,
// with hand-computed results for the reference network x=[7,-3].
`timescale 1ns/1ps
module tb_mlp_seq;
  import mlp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic        we    [3];
  logic [1:0]  ad    [3];
  logic [31:0] wd    [3];
  logic [31:0] rd    [3];
  logic        irq   [3];

  int checks = 0;
  int errors = 0;

  int hid_w [12] = '{1, 2, 3, 0, -1, 2, -2, 4, 1, 1, 1, 1};

`ifdef MLP_PERF_CNT_EN
  localparam logic [31:0] PERF_EXP = 32'd23;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  mlp_seq u_dut0 (
    .clk(clk), .rst(rst_n[0]), .write_en(we[0]), .addr(ad[0]),
    .writedata(wd[0]), .readdata(rd[0]), .irq(irq[0])
  );

  mlp_seq #(.N_OUTPUT(2), .OUT_WIDTH(8)) u_dut1 (
    .clk(clk), .rst(rst_n[1]), .write_en(we[1]), .addr(ad[1]),
    .writedata(wd[1]), .readdata(rd[1]), .irq(irq[1])
  );

  mlp_seq #(.FRAC_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst_n[2]), .write_en(we[2]), .addr(ad[2]),
    .writedata(wd[2]), .readdata(rd[2]), .irq(irq[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
    we[d] = 1'b1;
    ad[d] = a;
    wd[d] = v;
    @(posedge clk);
    #1;
    we[d] = 1'b0;
  endtask

  task automatic rd_reg(input int d, input logic [1:0] a, output logic [31:0] v);
    ad[d] = a;
    @(posedge clk);
    #1;
    v = rd[d];
  endtask

  // Counts edges after the RUN edge until irq rises; bounded so a dead DUT still ends the run.
  task automatic wait_done(input int d, input int exp_cyc, input string tag);
    int c = 0;
    while (!irq[d] && c < exp_cyc + 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, 32'(c), 32'(exp_cyc));
  endtask

  task automatic load_ref(input int d);
    wr(d, ADDR_INPUT, 32'd7);
    wr(d, ADDR_INPUT, 32'hFFFF_FFFD);
    for (int i = 0; i < 12; i++) wr(d, ADDR_WEIGHT, hid_w[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      we[d]    = 1'b0;
      ad[d]    = 2'd0;
      wd[d]    = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_irq", 32'(irq[0]), 32'd0);
    check("rst_readdata", rd[0], 32'd0);
    rd_reg(0, ADDR_CTRL, v);   check("rst_ctrl", v, 32'd0);
    rd_reg(0, ADDR_OUTPUT, v); check("rst_y0", v, 32'd0);

    // Reference network, ReLU hidden: 1+6+0+23+5 = 35 after 23 cycles
    wr(0, ADDR_CTRL, 32'h0);
    load_ref(0);
    wr(0, ADDR_CTRL, 32'h8);
    for (int i = 0; i < 5; i++) wr(0, ADDR_WEIGHT, 32'd1);
    wr(0, ADDR_CTRL, 32'h5);
    wait_done(0, 23, "lat_relu");
    check("irq_set", 32'(irq[0]), 32'd1);
    wr(0, ADDR_OUTPUT, 32'd0);
    rd_reg(0, ADDR_OUTPUT, v); check("y_relu", v, 32'd35);
    rd_reg(0, ADDR_CTRL, v);
    check("ctrl_done", 32'(v[15:0]), 32'h6);
    check("perf_cnt", 32'(v[31:16]), PERF_EXP);

    // DONE clear drops irq on the same edge
    wr(0, ADDR_CTRL, 32'h6);
    check("irq_clr", 32'(irq[0]), 32'd0);
    rd_reg(0, ADDR_CTRL, v); check("ctrl_clr", 32'(v[15:0]), 32'h4);

    // Identity hidden: 1+6-13+23+5 = 22
    wr(0, ADDR_CTRL, 32'h15);
    wait_done(0, 23, "lat_ident");
    rd_reg(0, ADDR_OUTPUT, v); check("y_ident", v, 32'd22);

    // INPUT and RUN written mid-run must be dropped
    wr(0, ADDR_CTRL, 32'h5);
    repeat (3) @(posedge clk);
    #1;
    wr(0, ADDR_INPUT, 32'd99);
    wr(0, ADDR_CTRL, 32'h5);
    rd_reg(0, ADDR_CTRL, v); check("busy_bit", 32'(v[CTRL_BUSY]), 32'd1);
    wait_done(0, 17, "lat_busy");
    rd_reg(0, ADDR_OUTPUT, v); check("y_busy", v, 32'd35);

    // 17 hidden writes: last five overwrite indices 0..4 -> h0=0, h1=relu(-1)=0, y=29
    wr(0, ADDR_CTRL, 32'h6);
    for (int i = 0; i < 12; i++) wr(0, ADDR_WEIGHT, hid_w[i]);
    wr(0, ADDR_WEIGHT, 32'd0);
    wr(0, ADDR_WEIGHT, 32'd0);
    wr(0, ADDR_WEIGHT, 32'd0);
    wr(0, ADDR_WEIGHT, 32'd5);
    wr(0, ADDR_WEIGHT, 32'd0);
    wr(0, ADDR_CTRL, 32'h5);
    wait_done(0, 23, "lat_wrap");
    rd_reg(0, ADDR_OUTPUT, v); check("y_wrap", v, 32'd29);

    // Reset during H_MAC with in_ptr left at 1
    wr(0, ADDR_INPUT, 32'd55);
    wr(0, ADDR_CTRL, 32'h5);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    #1;
    check("mid_rst_readdata", rd[0], 32'd0);
    check("mid_rst_irq", 32'(irq[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rd_reg(0, ADDR_CTRL, v);   check("mid_rst_ctrl", v, 32'd0);
    rd_reg(0, ADDR_OUTPUT, v); check("mid_rst_y0", v, 32'd0);
    load_ref(0);
    wr(0, ADDR_CTRL, 32'hC);
    for (int i = 0; i < 5; i++) wr(0, ADDR_WEIGHT, 32'd1);
    wr(0, ADDR_CTRL, 32'h5);
    wait_done(0, 23, "lat_reload");
    rd_reg(0, ADDR_OUTPUT, v); check("y_reload", v, 32'd35);

    // Two outputs, 8-bit results: latency 16+12+1 = 29
    wr(1, ADDR_CTRL, 32'h0);
    load_ref(1);
    wr(1, ADDR_CTRL, 32'h8);
    for (int i = 0; i < 5; i++) wr(1, ADDR_WEIGHT, 32'd1);
    wr(1, ADDR_WEIGHT, -32'sd100);
    for (int i = 0; i < 4; i++) wr(1, ADDR_WEIGHT, 32'd0);
    wr(1, ADDR_CTRL, 32'h5);
    wait_done(1, 29, "lat_two_out");
    wr(1, ADDR_OUTPUT, 32'd0);
    rd_reg(1, ADDR_OUTPUT, v); check("y0_two_out", v, 32'd35);
    wr(1, ADDR_OUTPUT, 32'd1);
    rd_reg(1, ADDR_OUTPUT, v); check("y1_neg100", v, 32'hFFFF_FF9C);

    // +/-40 on h2=23 gives +/-920, clamped to 127 / -128
    wr(1, ADDR_CTRL, 32'h6);
    wr(1, ADDR_CTRL, 32'h8);
    for (int i = 0; i < 10; i++) begin
      if (i == 3)      wr(1, ADDR_WEIGHT, -32'sd40);
      else if (i == 8) wr(1, ADDR_WEIGHT, 32'd40);
      else             wr(1, ADDR_WEIGHT, 32'd0);
    end
    wr(1, ADDR_CTRL, 32'h5);
    wait_done(1, 29, "lat_clamp");
    wr(1, ADDR_OUTPUT, 32'd3);
    rd_reg(1, ADDR_OUTPUT, v); check("y1_sat_hi", v, 32'd127);
    wr(1, ADDR_OUTPUT, 32'd0);
    rd_reg(1, ADDR_OUTPUT, v); check("y0_sat_lo", v, 32'hFFFF_FF80);

    // FRAC_BITS=2: -9 >>> 2 = -3, 23 >>> 2 = 5
    wr(2, ADDR_CTRL, 32'h18);
    wr(2, ADDR_WEIGHT, 32'hFFFF_FFF7);
    wr(2, ADDR_CTRL, 32'h15);
    wait_done(2, 23, "lat_frac");
    rd_reg(2, ADDR_OUTPUT, v); check("y_frac_neg", v, 32'hFFFF_FFFD);
    wr(2, ADDR_CTRL, 32'h1E);
    wr(2, ADDR_WEIGHT, 32'd23);
    wr(2, ADDR_CTRL, 32'h15);
    wait_done(2, 23, "lat_frac2");
    rd_reg(2, ADDR_OUTPUT, v); check("y_frac_pos", v, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_seq.md
Name: mlp_seq

Overview:
Parametrised successor of the fixed 2-4-1 mlp accelerator. It is a two-layer fully-connected network engine behind the same 2-bit register interface. Additions: any N_INPUTS/N_HIDDEN/N_OUTPUT, fixed-point rescale with saturation, selectable hidden activation, multi-output readback and a maskable level irq. A single sequential MAC (one product per cycle) serves both layers.

Parameters:
N_INPUTS, 2, inputs per sample (≥1)
N_HIDDEN, 4, hidden neurons (≥1)
N_OUTPUT, 1, output neurons (≥1)
IN_WIDTH, 16, signed input width (writedata[IN_WIDTH-1:0])
WGT_WIDTH, 16, signed weight width
MAC_WIDTH, 64, signed accumulator width
OUT_WIDTH, 16, signed width of hidden and output results
FRAC_BITS, 0, arithmetic right shift applied to each accumulator before saturation

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
write_en  in  1  register write strobe
addr  in  2  register select: 0 CTRL, 1 INPUT, 2 WEIGHT, 3 OUTPUT
writedata  in  32  write data
readdata  out  32  registered read data for addr, 1-cycle latency
irq  out  1  level interrupt = DONE & IRQ_EN

Behaviour:
- Reset (rst=0) is asynchronous and takes priority over everything, including mid-computation. It forces:
  - FSM to IDLE; readdata=0, irq=0
  - CTRL=0, all pointers=0, all input/weight/hidden/output storage=0
- CTRL bits:
  - bit0 RUN: write 1 starts a computation; self-clears.
  - bit1 DONE: RO; write 1 clears it.
  - bit2 IRQ_EN: R/W.
  - bit3 LAYER_SEL: R/W; 0 = hidden weights, 1 = output weights. Any write to bit3 resets the weight pointer to 0.
  - bit4 ACT: R/W; hidden activation, 0 = ReLU, 1 = identity. Output layer is always identity.
  - bit5 PTR_CLR: write 1 zeroes the input and weight pointers; self-clears.
  - bit6 BUSY: RO.
  - Other bits read 0.
- INPUT write: stores sign-truncated writedata into x[in_ptr]; in_ptr increments and wraps N_INPUTS-1 -> 0.
- WEIGHT write: stores into the selected layer array, neuron-major, bias first.
  - Hidden array: N_HIDDEN×(N_INPUTS+1).
  - Output array: N_OUTPUT×(N_HIDDEN+1).
  - Pointer wraps at the end of the array.
- OUTPUT write: sets rd_idx = writedata mod N_OUTPUT. Read returns y[rd_idx] sign-extended to 32 bits.
- Writes to INPUT, WEIGHT or RUN while BUSY are ignored. CTRL IRQ_EN, ACT and DONE-clear writes are still accepted while BUSY.
- FSM states: IDLE -> H_BIAS -> H_MAC -> H_WB -> (next hidden neuron, or O_BIAS) -> O_MAC -> O_WB -> (next output, or FIN) -> IDLE.
  - *_BIAS: acc = sign-extended bias.
  - *_MAC: one acc += w·x per cycle, products sign-extended to MAC_WIDTH.
  - *_WB: r = acc >>> FRAC_BITS, then activation, then clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. r is stored to h[j] or y[k].
  - FIN: sets DONE, clears BUSY.
- Latency: RUN accepted at edge T gives DONE=1 at T + N_HIDDEN·(N_INPUTS+2) + N_OUTPUT·(N_HIDDEN+2) + 1. Defaults: 23 cycles.
- RUN sets BUSY and clears DONE in the same edge.
- y is updated only at O_WB; old outputs remain readable until overwritten.
- Accumulator overflow beyond MAC_WIDTH wraps (two's complement). This is the caller's responsibility.

Optional Feature:
MLP_PERF_CNT_EN.
- Defined: a 16-bit cycle counter clears on RUN and increments each BUSY cycle, saturating at 0xFFFF. It reads in CTRL readdata[31:16].
- Undefined: readdata[31:16] of CTRL reads 0 and no counter logic exists.

Decomposition:
- mlp_pkg holds:
  - register address constants
  - CTRL bit indices
  - FSM state encodings
  - sat/shift helper function
- Sub-module mlp_mac_unit holds the accumulator, bias load, MAC step, and shift/activation/saturate writeback. It is instantiated once; mlp_seq keeps registers, storage, pointers and the FSM.

Test Plan:
- Defaults; x=[7,-3]; hidden weights [1,2,3],[0,-1,2],[-2,4,1],[1,1,1]; output [1,1,1,1,1]; ACT=0; RUN -> DONE after 23 cycles, OUTPUT idx0 reads 35; ACT=1 rerun -> 22.
- Same data, IRQ_EN=1 -> irq rises with DONE; write CTRL bit1=1 -> irq and DONE fall next cycle.
- N_OUTPUT=2, second output weights [-100,0,0,0,0], OUT_WIDTH=8 -> y1=-100. Output weight 40 on h2 (23·40=920) -> clamps to 127.
- Assert reset mid-H_MAC -> BUSY=0, readdata=0, pointers 0; a reload-and-run afterwards yields 35.
- While BUSY, write INPUT=99 and RUN -> ignored; result still 35. Five hidden weight writes after 12 wrap to index 0..4.
- FRAC_BITS=2, acc -9 identity -> r=-3 (arithmetic shift). With MLP_PERF_CNT_EN, CTRL[31:16]=23 after default run.
